// File: rtl/esm_issue_scheduler.sv
// esm_issue_scheduler: slot allocator and round-robin issue scheduler for the ESM instruction buffer
// Optional perf counters (perf_issued, perf_stall) under `ifdef ESM_SCHED_PERF_EN.
module esm_issue_scheduler #(
  parameter int bs = 16,
  parameter int IDA_LAT = 2,
`ifdef ESM_SCHED_PERF_EN
  parameter int CNT_W = 32,
`endif
  localparam int IW = $clog2(bs)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_req,
  output logic          alloc_gnt,
  output logic [IW-1:0] buffer_index,
  output logic [0:bs-1] valid_entries,
  input  logic [0:bs-1] independent_instr,
  output logic          issue_valid,
  output logic [IW-1:0] issue_index,
  input  logic          issue_ready,
  input  logic          done_valid,
  input  logic [IW-1:0] done_index,
  input  logic          flush,
  output logic          full,
  output logic          empty
`ifdef ESM_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_issued,
  output logic [CNT_W-1:0] perf_stall
`endif
);
  localparam int CW = IDA_LAT > 1 ? $clog2(IDA_LAT) : 1;
  typedef enum logic [1:0] {FREE, SETTLE, ELIG, ISSUED} slot_t;
  slot_t st [bs];
  logic [CW-1:0] ctr [bs];
  logic [IW-1:0] rr_ptr, pick, j;
  logic [bs-1:0] cand;
  logic any, fire;
  assign fire = issue_valid & issue_ready;
  assign full = &valid_entries;
  assign empty = ~|valid_entries;
  assign alloc_gnt = alloc_req & ~full;
  always_comb begin
    buffer_index = '0;
    for (int i = bs-1; i >= 0; i--)
      if (st[i] == FREE) buffer_index = IW'(i);
  end
  // The presented slot is still ELIG until it fires, so keep it out of the candidates.
  always_comb
    for (int i = 0; i < bs; i++) begin
      valid_entries[i] = st[i] != FREE;
      cand[i] = st[i] == ELIG && independent_instr[i] && !(issue_valid && issue_index == IW'(i));
    end
  always_comb begin
    pick = '0;
    any = 1'b0;
    j = '0;
    for (int k = bs-1; k >= 0; k--) begin
      j = rr_ptr + IW'(k);
      if (cand[j]) begin
        pick = j;
        any = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < bs; i++) begin
        st[i] <= FREE;
        ctr[i] <= '0;
      end
      issue_valid <= 1'b0;
      issue_index <= '0;
      rr_ptr <= '0;
    end else if (flush) begin
      for (int i = 0; i < bs; i++) begin
        st[i] <= FREE;
        ctr[i] <= '0;
      end
      issue_valid <= 1'b0;
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < bs; i++) begin
        if (st[i] == SETTLE) begin
          if (ctr[i] == '0) st[i] <= ELIG;
          else ctr[i] <= ctr[i] - 1'b1;
        end
        if (st[i] == ISSUED && done_valid && done_index == IW'(i)) st[i] <= FREE;
      end
      if (fire) begin
        st[issue_index] <= ISSUED;
        rr_ptr <= issue_index + 1'b1;
      end
      if (alloc_gnt) begin
        st[buffer_index] <= SETTLE;
        ctr[buffer_index] <= CW'(IDA_LAT - 1);
      end
      if (~issue_valid | fire) begin
        issue_valid <= any;
        if (any) issue_index <= pick;
      end
    end
`ifdef ESM_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst | flush) begin
      perf_issued <= '0;
      perf_stall <= '0;
    end else begin
      if (fire && ~&perf_issued) perf_issued <= perf_issued + 1'b1;
      if (issue_valid && !issue_ready && ~&perf_stall) perf_stall <= perf_stall + 1'b1;
    end
`endif
endmodule

// File: tb/tb_esm_issue_scheduler.sv
// tb_esm_issue_scheduler: directed stimulus checked against a timestamp-based slot model plus literal expectations
module tb_esm_issue_scheduler;
  localparam int BS = 16;
  localparam int LAT = 2;
  logic clk = 0, rst = 0;
  logic alloc_req = 0, issue_ready = 0, done_valid = 0, flush = 0;
  logic [3:0] done_index = 0;
  logic [0:BS-1] independent_instr = '0;
  logic alloc_gnt, issue_valid, full, empty;
  logic [3:0] buffer_index, issue_index;
  logic [0:BS-1] valid_entries;
`ifdef ESM_SCHED_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif
  int n_chk = 0, n_fail = 0;

  esm_issue_scheduler dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .buffer_index(buffer_index), .valid_entries(valid_entries),
    .independent_instr(independent_instr), .issue_valid(issue_valid),
    .issue_index(issue_index), .issue_ready(issue_ready), .done_valid(done_valid),
    .done_index(done_index), .flush(flush), .full(full), .empty(empty)
`ifdef ESM_SCHED_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: per slot 0=free 1=allocated-not-issued 2=issued; eligibility from allocation timestamp.
  int ms[BS], ta[BS], me, mi, mrr;
  bit mv;

  function automatic int m_free();
    for (int i = 0; i < BS; i++) if (ms[i] == 0) return i;
    return -1;
  endfunction

  function automatic bit m_elig(int s);
    return ms[s] == 1 && me >= ta[s] + LAT;
  endfunction

  always @(posedge clk or posedge rst) begin
    int fi, pk, jj;
    bit fire, gnt, found;
    if (rst) begin
      for (int i = 0; i < BS; i++) ms[i] = 0;
      mv = 0; mi = 0; mrr = 0; me = 0;
    end else begin
      fire = mv && issue_ready;
      fi = m_free();
      gnt = alloc_req && fi >= 0;
      found = 0; pk = 0;
      for (int k = 0; k < BS && !found; k++) begin
        jj = (mrr + k) % BS;
        if (m_elig(jj) && independent_instr[jj] && !(mv && jj == mi)) begin
          found = 1; pk = jj;
        end
      end
      me++;
      if (flush) begin
        for (int i = 0; i < BS; i++) ms[i] = 0;
        mv = 0; mrr = 0;
      end else begin
        if (done_valid && ms[done_index] == 2) ms[done_index] = 0;
        if (fire) begin ms[mi] = 2; mrr = (mi + 1) % BS; end
        if (gnt) begin ms[fi] = 1; ta[fi] = me; end
        if (!mv || fire) begin mv = found; if (found) mi = pk; end
      end
    end
  end

  always @(negedge clk) begin
    logic [0:BS-1] ve;
    int fi;
    if (!rst) begin
      for (int i = 0; i < BS; i++) ve[i] = ms[i] != 0;
      fi = m_free();
      check("m_alloc_gnt", alloc_gnt, alloc_req && fi >= 0);
      check("m_buffer_index", buffer_index, fi < 0 ? 0 : fi);
      check("m_valid_entries", valid_entries, ve);
      check("m_full", full, fi < 0);
      check("m_empty", empty, ve == 0);
      check("m_issue_valid", issue_valid, mv);
      if (mv) check("m_issue_index", issue_index, mi);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_issue(input int exp, input string nm);
    int k;
    k = 0;
    #1;
    while (!issue_valid && k < 30) begin cyc(); #1; k++; end
    if (!issue_valid) begin
      n_chk++; n_fail++;
      $display("FAIL %s: issue_valid never rose, expected index %0d", nm, exp);
    end else check(nm, issue_index, exp);
  endtask

  task automatic do_flush();
    flush = 1; cyc(); flush = 0; #1;
    check("flush_empty", empty, 1);
  endtask

  initial begin
    // 1: reset, three allocations, back-to-back issue
    rst = 1; cyc(2); rst = 0; #1;
    check("rst_valid_entries", valid_entries, 0);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_issue_index", issue_index, 0);
    check("rst_empty", empty, 1);
    alloc_req = 1; independent_instr = '1; issue_ready = 1; #1;
    check("t1_gnt", alloc_gnt, 1);
    check("t1_idx0", buffer_index, 0);
    cyc(); #1 check("t1_idx1", buffer_index, 1);
    cyc(); #1 check("t1_idx2", buffer_index, 2);
    cyc(); alloc_req = 0; #1;
    check("t1_valid_entries", valid_entries, 16'hE000);
    check("t1_not_yet", issue_valid, 0);
    cyc(); #1 check("t1_first_valid", issue_valid, 1); check("t1_iss0", issue_index, 0);
    cyc(); #1 check("t1_iss1", issue_index, 1); check("t1_v1", issue_valid, 1);
    cyc(); #1 check("t1_iss2", issue_index, 2); check("t1_v2", issue_valid, 1);
    cyc(); #1 check("t1_drain", issue_valid, 0);
    for (int s = 0; s < 3; s++) begin done_valid = 1; done_index = 4'(s); cyc(); end
    done_valid = 0; #1 check("t1_empty", empty, 1);
    // 2: fill, full, free slot 5
    alloc_req = 1; cyc(16); #1;
    check("t2_full", full, 1);
    check("t2_gnt17", alloc_gnt, 0);
    cyc(8); #1 check("t2_all_issued", issue_valid, 0);
    done_valid = 1; done_index = 5; #1 check("t2_still_full", full, 1);
    cyc(); done_valid = 0; #1;
    check("t2_gnt", alloc_gnt, 1);
    check("t2_idx5", buffer_index, 5);
    alloc_req = 0;
    do_flush();
    // 3: slots 3 and 7 held back, then released; rr wraps 7 -> 0
    independent_instr = '0;
    for (int s = 0; s < 7; s++) if (s != 3) independent_instr[s] = 1;
    alloc_req = 1; cyc(8); alloc_req = 0; cyc(8);
    for (int s = 0; s < 7; s++) if (s != 3) begin done_valid = 1; done_index = 4'(s); cyc(); end
    done_valid = 0; independent_instr = '0; independent_instr[7] = 1;
    wait_issue(7, "t3_iss7");
    independent_instr[3] = 1;
    cyc(); wait_issue(3, "t3_iss3");
    cyc(); #1 check("t3_drain", issue_valid, 0);
    do_flush();
    // 4: stall with ready low, index held even when independence drops
    independent_instr = '0; independent_instr[4] = 1; issue_ready = 0;
    alloc_req = 1; cyc(5); alloc_req = 0;
    wait_issue(4, "t4_iss4");
    independent_instr = '0;
    repeat (5) begin cyc(); #1 check("t4_hold", issue_index, 4); check("t4_hold_v", issue_valid, 1); end
`ifdef ESM_SCHED_PERF_EN
    check("t4_perf_stall", perf_stall, 5);
`endif
    issue_ready = 1; cyc(); #1 check("t4_single_fire", issue_valid, 0);
`ifdef ESM_SCHED_PERF_EN
    check("t4_perf_issued", perf_issued, 1);
`endif
    // 5: flush beats alloc, done and fire in the same cycle
    independent_instr = '0; independent_instr[0] = 1; issue_ready = 0;
    wait_issue(0, "t5_iss0");
    alloc_req = 1; issue_ready = 1; done_valid = 1; done_index = 4; flush = 1; #1;
    check("t5_gnt_comb", alloc_gnt, 1);
    cyc(); alloc_req = 0; issue_ready = 0; done_valid = 0; flush = 0; #1;
    check("t5_valid_entries", valid_entries, 0);
    check("t5_issue_valid", issue_valid, 0);
    check("t5_empty", empty, 1);
    cyc(4); #1 check("t5_no_survivor", empty, 1);
    // 6: done on a free slot is ignored; async reset mid-issue
    alloc_req = 1; cyc(2); alloc_req = 0; #1 check("t6_two", valid_entries, 16'hC000);
    done_valid = 1; done_index = 9; cyc(); done_valid = 0; #1;
    check("t6_ignored", valid_entries, 16'hC000);
    independent_instr = '1;
    wait_issue(0, "t6_iss0");
    #1 rst = 1; #1;
    check("t6_rst_valid", issue_valid, 0);
    check("t6_rst_index", issue_index, 0);
    check("t6_rst_entries", valid_entries, 0);
    check("t6_rst_empty", empty, 1);
    cyc(); rst = 0; cyc(2); #1 check("t6_after", empty, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
